exmem_reg: RTL and testbench
============================

# exmem_reg

EX/MEM pipeline register for the semiMIPS 5-stage core, placed between the execute stage and the memory-stage data-path mux. It latches the ALU result, the store data and the control bits each cycle, with stall and flush support. It also generates the registered `memdata` select that drives the memory-stage data mux. `memdata` is set when a `sw` enters MEM directly behind a `lw` whose destination is the store's `rt`, so the mux then takes the data-memory output from MEM/WB instead of stale register-file data.

## Interface
Parameters:
- `DWIDTH`, 32, data-path width
- `AWIDTH`, 5, register-number width

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  hold all outputs this cycle
- `flush`  in  1  load a bubble this cycle; has priority over `stall`
- `ex_valid`  in  1  EX holds a real instruction
- `ex_aluout`  in  DWIDTH  ALU result (memory address or writeback value)
- `ex_regdata`  in  DWIDTH  `rt` value after EX forwarding (store data)
- `ex_rt`  in  AWIDTH  `rt` field of the EX instruction
- `ex_wreg`  in  AWIDTH  destination register of the EX instruction
- `ex_memread`, `ex_memwrite`, `ex_regwrite`, `ex_memtoreg`  in  1 each  EX control bits
- `mem_valid`  out  1  MEM holds a real instruction
- `mem_aluout`  out  DWIDTH  to data-memory address and to MEM/WB
- `mem_regdata`  out  DWIDTH  to the mux `regdata` input
- `mem_wreg`  out  AWIDTH  registered destination
- `mem_rt`  out  AWIDTH  registered `rt`
- `mem_memread`, `mem_memwrite`, `mem_regwrite`, `mem_memtoreg`  out  1 each  registered control
- `memdata`  out  1  mux select: 0 = register data, 1 = data-memory data

## Operation
- **Reset:** all outputs go to 0 immediately and stay 0 while `rst` is high. 0 is a bubble with `memdata`=0.
- **Priority each edge:** `rst` > `flush` > `stall` > load.
- **Load:** every `mem_*` output takes its `ex_*` counterpart.
- **Control gating on load:** the four control bits are ANDed with `ex_valid`. Data fields are loaded unconditionally.
- **`memdata` on load:** next value is 1 only when all of the following hold at the edge; otherwise 0:
  - `ex_valid` & `ex_memwrite`
  - `mem_valid` & `mem_memread` & `mem_regwrite` (the current MEM instruction, which moves to WB on the same edge)
  - `mem_wreg` == `ex_rt`
  - `ex_rt` != 0
- **Flush:** `mem_valid`, all control bits and `memdata` go to 0. Data and register fields also go to 0, so bubbles are deterministic.
- **Stall:** every output holds, including `memdata`. The upstream stage owner guarantees MEM/WB holds as well.
- **Store data:** `mem_regdata` is never modified here. Forward selection is done only by the downstream mux.

## Timing
- Latency is 1 cycle from `ex_*` to `mem_*`. `memdata` is valid in the same cycle as the `sw` it qualifies.
- `memdata` is a registered output only; there is no combinational path from inputs to outputs.
- **Back-to-back `lw`→`sw`, same `rt`:** `memdata`=1 for exactly the one MEM cycle of the `sw`, then returns to 0 unless a new match occurs.
- **`lw`, bubble, `sw`:** `memdata`=0, because the EX-stage forward covers this case.
- **`stall` held N cycles:** outputs are frozen for N cycles; the next load uses the `mem_*` values frozen at that time.
- **`flush` and `stall` together:** flush wins and a bubble loads.
- **`rst` asserted mid-stream:** outputs clear asynchronously. Operation resumes on the first edge after `rst` deasserts.

## Structure
- Shared package/header `semimips_pkg`:
  - `DWIDTH` = 32, `AWIDTH` = 5, `REG_ZERO` = 0
  - `MEMDATA_REG` = 1'b0, `MEMDATA_DM` = 1'b1, shared with the memory-stage mux
- One sub-module, `memfwd_detect`: purely combinational; computes the next `memdata` from `ex_*` and the current `mem_*` fields. It is reused by the hazard unit for assertions.

## Test plan
- **Reset:** assert `rst` mid-cycle with all inputs = 1 → all outputs read 0 before the next edge and stay 0 until release.
- **Pass-through:** `ex_aluout`=0x10, `ex_regdata`=0xDEADBEEF, `ex_wreg`=8, `ex_regwrite`=1 → next cycle same values on `mem_*`, `memdata`=0.
- **`lw` $9 then `sw` $9:** cycle n `lw` (`ex_memread`=1, `ex_regwrite`=1, `ex_wreg`=9); cycle n+1 `sw` (`ex_memwrite`=1, `ex_rt`=9) → `memdata`=1 in cycle n+2 only.
  - Repeat with `rt`=0 → `memdata`=0.
  - Repeat with `rt`=10 → `memdata`=0.
- **Stall:** `lw`/`sw` match, then `stall`=1 for 3 cycles → `memdata`=1 and all fields held for 3 cycles; after release the next load clears `memdata` when no new match exists.
- **Flush over stall:** `stall`=1 and `flush`=1 with a `sw` in EX → next cycle `mem_valid`=0, all control bits = 0, `memdata`=0.
- **Bubble gating:** `ex_valid`=0 with `ex_memwrite`=1 → `mem_memwrite`=0, `memdata`=0.

Source files
------------

// File: rtl/semimips_pkg.sv
// semimips_pkg
// Widths and encodings shared across the semiMIPS pipeline.
//   DWIDTH      : data-path width
//   AWIDTH      : register-number width
//   REG_ZERO    : register number of the hard-wired zero register
//   MEMDATA_REG : memory-stage mux select for register-file data
//   MEMDATA_DM  : memory-stage mux select for data-memory data
package semimips_pkg;

  localparam int DWIDTH   = 32;
  localparam int AWIDTH   = 5;
  localparam int REG_ZERO = 0;

  localparam logic MEMDATA_REG = 1'b0;
  localparam logic MEMDATA_DM  = 1'b1;

endpackage

// File: rtl/exmem_reg_memfwd_detect.sv
// memfwd_detect
// Combinational detector for a load-to-store hazard that can only be
// resolved in MEM. It produces the next value of the memory-stage mux select.
// The select is MEMDATA_DM when a valid store in EX uses as its rt the
// destination of a valid, register-writing load that is now in MEM.
// Ports:
//   ex_valid, ex_memwrite, ex_rt        : the instruction about to enter MEM
//   mem_valid, mem_memread,
//   mem_regwrite, mem_wreg              : the instruction now in MEM
//   memdata_nxt                         : select to register for the store
module memfwd_detect #(
  parameter int AWIDTH = semimips_pkg::AWIDTH
) (
  input  logic              ex_valid,
  input  logic              ex_memwrite,
  input  logic [AWIDTH-1:0] ex_rt,
  input  logic              mem_valid,
  input  logic              mem_memread,
  input  logic              mem_regwrite,
  input  logic [AWIDTH-1:0] mem_wreg,
  output logic              memdata_nxt
);

  import semimips_pkg::*;

  logic store_in_ex;
  logic load_in_mem;
  logic rt_match;

  assign store_in_ex = ex_valid & ex_memwrite;
  assign load_in_mem = mem_valid & mem_memread & mem_regwrite;
  // $zero is never really written, so a store of $zero cannot depend on the load.
  assign rt_match    = (mem_wreg == ex_rt) && (ex_rt != AWIDTH'(REG_ZERO));

  assign memdata_nxt = (store_in_ex & load_in_mem & rt_match) ? MEMDATA_DM : MEMDATA_REG;

endmodule

// File: rtl/exmem_reg.sv
// exmem_reg
// EX/MEM pipeline register of the semiMIPS core. It latches the ALU result,
// the store data, the register fields and the control bits. It also registers
// the memory-stage mux select (memdata) for a store directly behind a load
// to the same register.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   stall, flush        : hold outputs / load a bubble (flush wins)
//   ex_*                : execute-stage instruction fields and control
//   mem_*               : registered copies for the memory stage
//   memdata             : mux select, 0 = register data, 1 = data-memory data
module exmem_reg #(
  parameter int DWIDTH = semimips_pkg::DWIDTH,
  parameter int AWIDTH = semimips_pkg::AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DWIDTH-1:0] ex_aluout,
  input  logic [DWIDTH-1:0] ex_regdata,
  input  logic [AWIDTH-1:0] ex_rt,
  input  logic [AWIDTH-1:0] ex_wreg,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  output logic              mem_valid,
  output logic [DWIDTH-1:0] mem_aluout,
  output logic [DWIDTH-1:0] mem_regdata,
  output logic [AWIDTH-1:0] mem_wreg,
  output logic [AWIDTH-1:0] mem_rt,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_regwrite,
  output logic              mem_memtoreg,
  output logic              memdata
);

  logic              vld_p1;
  logic [DWIDTH-1:0] aluout_p1;
  logic [DWIDTH-1:0] regdata_p1;
  logic [AWIDTH-1:0] wreg_p1;
  logic [AWIDTH-1:0] rt_p1;
  logic              memread_p1;
  logic              memwrite_p1;
  logic              regwrite_p1;
  logic              memtoreg_p1;
  logic              memdata_p1;
  logic              memdata_nxt;

  // The detector looks at the instruction still in MEM (about to move to WB)
  // and the one entering from EX on the same edge.
  memfwd_detect #(
    .AWIDTH (AWIDTH)
  ) u_memfwd_detect (
    .ex_valid     (ex_valid),
    .ex_memwrite  (ex_memwrite),
    .ex_rt        (ex_rt),
    .mem_valid    (vld_p1),
    .mem_memread  (memread_p1),
    .mem_regwrite (regwrite_p1),
    .mem_wreg     (wreg_p1),
    .memdata_nxt  (memdata_nxt)
  );

  // ---- EX -> MEM stage boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      aluout_p1   <= '0;
      regdata_p1  <= '0;
      wreg_p1     <= '0;
      rt_p1       <= '0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      regwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      memdata_p1  <= 1'b0;
    end else if (flush) begin
      // Bubbles are fully zeroed, including data, so they look the same every time.
      vld_p1      <= 1'b0;
      aluout_p1   <= '0;
      regdata_p1  <= '0;
      wreg_p1     <= '0;
      rt_p1       <= '0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      regwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      memdata_p1  <= 1'b0;
    end else if (!stall) begin
      // Data fields load unconditionally; only control is gated by ex_valid.
      vld_p1      <= ex_valid;
      aluout_p1   <= ex_aluout;
      regdata_p1  <= ex_regdata;
      wreg_p1     <= ex_wreg;
      rt_p1       <= ex_rt;
      memread_p1  <= ex_memread  & ex_valid;
      memwrite_p1 <= ex_memwrite & ex_valid;
      regwrite_p1 <= ex_regwrite & ex_valid;
      memtoreg_p1 <= ex_memtoreg & ex_valid;
      memdata_p1  <= memdata_nxt;
    end
  end

  assign mem_valid    = vld_p1;
  assign mem_aluout   = aluout_p1;
  assign mem_regdata  = regdata_p1;
  assign mem_wreg     = wreg_p1;
  assign mem_rt       = rt_p1;
  assign mem_memread  = memread_p1;
  assign mem_memwrite = memwrite_p1;
  assign mem_regwrite = regwrite_p1;
  assign mem_memtoreg = memtoreg_p1;
  assign memdata      = memdata_p1;

endmodule

// File: tb/tb_exmem_reg.sv
// tb_exmem_reg
// Self-checking bench for exmem_reg: directed scenarios with hand-computed
// expectations, then randomized traffic checked every cycle against an
// instruction-level model of what occupies the MEM stage.
module tb_exmem_reg;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall, flush, ex_valid;
  logic [DW-1:0] ex_aluout, ex_regdata;
  logic [AW-1:0] ex_rt, ex_wreg;
  logic          ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
  logic          mem_valid;
  logic [DW-1:0] mem_aluout, mem_regdata;
  logic [AW-1:0] mem_wreg, mem_rt;
  logic          mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg;
  logic          memdata;

  exmem_reg #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_aluout(ex_aluout), .ex_regdata(ex_regdata),
    .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .mem_valid(mem_valid), .mem_aluout(mem_aluout), .mem_regdata(mem_regdata),
    .mem_wreg(mem_wreg), .mem_rt(mem_rt),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .memdata(memdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // What the MEM stage is holding, described as an instruction.
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] alu;
    logic [DW-1:0] rd;
    logic [AW-1:0] wreg;
    logic [AW-1:0] rt;
    logic          mr, mw, rw, mt;
    logic          md;
  } minstr_t;

  minstr_t m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: a bubble is all zero; a loaded instruction
  // carries its fields, control only if it is real, and is marked for
  // memory-data forwarding when it is a store that reads what the load
  // just ahead of it (leaving MEM now) is writing.
  always @(posedge clk or posedge rst) begin
    minstr_t n;
    bit older_is_load, is_store;
    if (rst || flush) begin
      m = '0;
    end else if (!stall) begin
      older_is_load = m.valid && m.mr && m.rw;
      is_store      = ex_valid && ex_memwrite;
      n.valid = ex_valid;
      n.alu   = ex_aluout;
      n.rd    = ex_regdata;
      n.wreg  = ex_wreg;
      n.rt    = ex_rt;
      n.mr    = ex_valid && ex_memread;
      n.mw    = ex_valid && ex_memwrite;
      n.rw    = ex_valid && ex_regwrite;
      n.mt    = ex_valid && ex_memtoreg;
      n.md    = is_store && older_is_load && (ex_rt == m.wreg) && (ex_rt != 0);
      m = n;
    end
  end

  always @(posedge clk) begin
    if (cmp_en) begin
      #2;
      check("model.valid",    mem_valid,    m.valid);
      check("model.aluout",   mem_aluout,   m.alu);
      check("model.regdata",  mem_regdata,  m.rd);
      check("model.wreg",     mem_wreg,     m.wreg);
      check("model.rt",       mem_rt,       m.rt);
      check("model.memread",  mem_memread,  m.mr);
      check("model.memwrite", mem_memwrite, m.mw);
      check("model.regwrite", mem_regwrite, m.rw);
      check("model.memtoreg", mem_memtoreg, m.mt);
      check("model.memdata",  memdata,      m.md);
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] rd,
                       input logic [AW-1:0] rt, input logic [AW-1:0] wreg,
                       input logic mr, input logic mw, input logic rw, input logic mt);
    ex_valid = v; ex_aluout = alu; ex_regdata = rd; ex_rt = rt; ex_wreg = wreg;
    ex_memread = mr; ex_memwrite = mw; ex_regwrite = rw; ex_memtoreg = mt;
  endtask

  task automatic lw(input logic [AW-1:0] r);
    @(negedge clk); drive(1, 32'h100, 32'h0, 5'd0, r, 1, 0, 1, 1);
  endtask

  task automatic sw(input logic [AW-1:0] r);
    @(negedge clk); drive(1, 32'h200, 32'h5555, r, 5'd0, 0, 1, 0, 0);
  endtask

  task automatic nop();
    @(negedge clk); drive(0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  // Wait for the load edge, then sample away from it.
  task automatic edge_wait();
    @(posedge clk); #3;
  endtask

  task automatic expect_all_zero(input string name);
    check({name, ".valid"},   mem_valid,    1'b0);
    check({name, ".aluout"},  mem_aluout,   32'h0);
    check({name, ".regdata"}, mem_regdata,  32'h0);
    check({name, ".wreg"},    mem_wreg,     5'd0);
    check({name, ".rt"},      mem_rt,       5'd0);
    check({name, ".ctrl"},    {mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg}, 4'b0000);
    check({name, ".memdata"}, memdata,      1'b0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 expect_all_zero("reset");
    @(negedge clk); rst = 1'b0;
    cmp_en = 1'b1;

    // Pass-through of a plain ALU instruction.
    @(negedge clk); drive(1, 32'h10, 32'hDEADBEEF, 5'd0, 5'd8, 0, 0, 1, 0);
    edge_wait();
    check("pass.valid",   mem_valid,   1'b1);
    check("pass.aluout",  mem_aluout,  32'h10);
    check("pass.regdata", mem_regdata, 32'hDEADBEEF);
    check("pass.wreg",    mem_wreg,    5'd8);
    check("pass.ctrl",    {mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg}, 4'b0010);
    check("pass.memdata", memdata,     1'b0);

    // lw $9 then sw $9: memdata only for the sw's MEM cycle.
    lw(5'd9); edge_wait();
    check("lwsw.lw_cycle", memdata, 1'b0);
    sw(5'd9); edge_wait();
    check("lwsw.sw_cycle", memdata, 1'b1);
    check("lwsw.sw_rt",    mem_rt,  5'd9);
    check("lwsw.sw_mw",    mem_memwrite, 1'b1);
    nop(); edge_wait();
    check("lwsw.after", memdata, 1'b0);

    // $zero never forwards.
    lw(5'd0); edge_wait();
    sw(5'd0); edge_wait();
    check("lwsw.rt0", memdata, 1'b0);

    // Different register.
    lw(5'd9); edge_wait();
    sw(5'd10); edge_wait();
    check("lwsw.rt10", memdata, 1'b0);

    // A bubble in between: EX forwarding covers it.
    lw(5'd9); edge_wait();
    nop(); edge_wait();
    sw(5'd9); edge_wait();
    check("lw_bubble_sw", memdata, 1'b0);

    // Stall for three cycles on a matched sw.
    lw(5'd9); edge_wait();
    sw(5'd9); edge_wait();
    @(negedge clk); stall = 1'b1; drive(1, 32'hFFFF, 32'h1234, 5'd9, 5'd9, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      check("stall.memdata", memdata, 1'b1);
      check("stall.aluout",  mem_aluout, 32'h200);
      check("stall.regdata", mem_regdata, 32'h5555);
      check("stall.rt",      mem_rt, 5'd9);
    end
    @(negedge clk); stall = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    edge_wait();
    check("stall.release", memdata, 1'b0);

    // Flush beats stall with a matching sw in EX.
    lw(5'd9); edge_wait();
    @(negedge clk); stall = 1'b1; flush = 1'b1; drive(1, 32'h200, 32'h5555, 5'd9, 5'd0, 0, 1, 0, 0);
    edge_wait();
    expect_all_zero("flush");
    @(negedge clk); stall = 1'b0; flush = 1'b0;

    // ex_valid=0 gates control and memdata but not the fields.
    lw(5'd9); edge_wait();
    @(negedge clk); drive(0, 32'h300, 32'h77, 5'd9, 5'd3, 1, 1, 1, 1);
    edge_wait();
    check("bubble.valid",   mem_valid,    1'b0);
    check("bubble.mw",      mem_memwrite, 1'b0);
    check("bubble.ctrl",    {mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg}, 4'b0000);
    check("bubble.memdata", memdata,      1'b0);
    check("bubble.rt",      mem_rt,       5'd9);
    check("bubble.aluout",  mem_aluout,   32'h300);

    // Mid-cycle asynchronous reset with every input high.
    lw(5'd9); edge_wait();
    @(negedge clk);
    stall = 1'b1; flush = 1'b1;
    drive(1, '1, '1, '1, '1, 1, 1, 1, 1);
    #2 rst = 1'b1;
    #1 expect_all_zero("async_rst");
    edge_wait();
    expect_all_zero("rst_held");
    @(negedge clk); rst = 1'b0; stall = 1'b0; flush = 1'b0;

    // Randomized traffic with a small register pool to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      int kind;
      logic [AW-1:0] r;
      @(negedge clk);
      kind = $urandom_range(0, 9);
      r    = AW'($urandom_range(0, 3));
      stall = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 5);
      if (kind < 4)
        drive($urandom_range(0, 9) != 0, $urandom, $urandom, AW'($urandom_range(0, 3)), r, 1, 0, 1, 1);
      else if (kind < 8)
        drive($urandom_range(0, 9) != 0, $urandom, $urandom, r, AW'($urandom_range(0, 3)), 0, 1, 0, 0);
      else
        drive($urandom_range(0, 1), $urandom, $urandom, AW'($urandom), AW'($urandom),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    @(negedge clk); stall = 1'b0; flush = 1'b0;
    @(posedge clk); #4;
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
